// File: rtl/demapper_ctrl_wifi.sv
// demapper_ctrl_wifi
// Frame sequencer between the 64-point FFT output and the constellation
// demapper bank. Latches modulation and symbol count at frame start, tracks
// the subcarrier index of the incoming bin stream, drops DC/pilot/null bins,
// steers the 48 data bins of each OFDM symbol to one demapper through a
// one-hot valid, and flags symbol and frame completion downstream.

module demapper_ctrl_wifi #(
  parameter int DATA_W = 12,
  parameter int NUM_SC = 64,
  parameter int SYM_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mod_sel,
  input  logic [SYM_W-1:0]  i_num_sym,
  input  logic              i_valid_in,
  input  logic [DATA_W-1:0] i_data_in_real,
  input  logic [DATA_W-1:0] i_data_in_imag,
  output logic [3:0]        o_demap_valid,
  output logic [DATA_W-1:0] o_data_out_real,
  output logic [DATA_W-1:0] o_data_out_imag,
  output logic [8:0]        o_bits_per_sym,
  output logic              o_busy,
  output logic              o_sym_done,
  output logic              o_frame_done,
  output logic [SYM_W-1:0]  o_sym_cnt
);

  // Index of the last bin of a symbol; bin 63 is always a data bin.
  localparam logic [5:0]       LAST_SC = 6'(NUM_SC - 1);
  localparam logic [SYM_W-1:0] SYM_ONE = SYM_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Data bins are everything except DC (0), pilots (7, 21, 43, 57) and the
  // guard/null band 27..37 -- 48 bins per symbol.
  function automatic logic f_is_data(input logic [5:0] idx);
    logic null_band;
    null_band = (idx >= 6'd27) && (idx <= 6'd37);
    return !(null_band || idx == 6'd0 || idx == 6'd7 || idx == 6'd21 ||
             idx == 6'd43 || idx == 6'd57);
  endfunction

  // Demapper select: bit0 BPSK, bit1 QPSK, bit2 16-QAM, bit3 64-QAM.
  function automatic logic [3:0] f_onehot(input logic [1:0] mod);
    return 4'b0001 << mod;
  endfunction

  // Coded bits per OFDM symbol: 48 data bins times bits per subcarrier.
  function automatic logic [8:0] f_bits(input logic [1:0] mod);
    logic [8:0] bits;
    case (mod)
      2'b00:   bits = 9'd48;
      2'b01:   bits = 9'd96;
      2'b10:   bits = 9'd192;
      default: bits = 9'd288;
    endcase
    return bits;
  endfunction

  // FSM and frame context
  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_mod;
  logic [SYM_W-1:0]    r_num_sym;
  logic [8:0]          r_bits_per_sym;
  logic [5:0]          r_sc_idx;
  logic [SYM_W-1:0]    r_sym_cnt;

  // Registered outputs toward the demappers / decoder control
  logic [3:0]          r_demap_valid;
  logic [DATA_W-1:0]   r_data_real;
  logic [DATA_W-1:0]   r_data_imag;
  logic                r_sym_done;
  logic                r_frame_done;

  // Decoded per-cycle events
  logic                w_in_run;
  logic                w_start_frame;
  logic                w_accept;
  logic                w_capture;
  logic                w_last_bin;
  logic [SYM_W-1:0]    w_sym_cnt_inc;
  logic                w_frame_end;

  // Next values of the registered outputs and counters
  logic [5:0]          w_sc_idx_next;
  logic [SYM_W-1:0]    w_sym_cnt_next;
  logic [3:0]          w_demap_valid_next;
  logic                w_sym_done_next;
  logic                w_frame_done_next;

  // Event decode: abort takes priority over any sample in the same cycle,
  // so an aborted bin is never accepted and never completes a symbol.
  always_comb begin
    w_in_run      = (r_state == ST_RUN);
    w_start_frame = (r_state == ST_IDLE) && i_start && (i_num_sym != '0);
    w_accept      = w_in_run && i_valid_in && !i_abort;
    w_capture     = w_accept && f_is_data(r_sc_idx);
    w_last_bin    = w_accept && (r_sc_idx == LAST_SC);
    w_sym_cnt_inc = r_sym_cnt + SYM_ONE;
    w_frame_end   = w_last_bin && (w_sym_cnt_inc == r_num_sym);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: every clocked assignment uses <= so all registers sample the
      // same pre-edge values regardless of statement or block order.
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a frame runs until its last symbol completes or abort
  always_comb begin
    // NOTE: a default before the case gives every path an assignment, so
    // no latch is inferred for combinational outputs.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_frame) w_state_next = ST_RUN;
      ST_RUN:  if (i_abort || w_frame_end) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the strobes, bin index and symbol counter
  always_comb begin
    w_sc_idx_next      = r_sc_idx;
    w_sym_cnt_next     = r_sym_cnt;
    w_demap_valid_next = 4'b0000;
    w_sym_done_next    = 1'b0;
    w_frame_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          // A zero-length frame completes at once without entering RUN.
          w_sc_idx_next     = 6'd0;
          w_sym_cnt_next    = '0;
          w_frame_done_next = (i_num_sym == '0);
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_sc_idx_next = 6'd0;
        end else if (i_valid_in) begin
          w_sc_idx_next = r_sc_idx + 6'd1;
          if (w_capture) w_demap_valid_next = f_onehot(r_mod);
          if (w_last_bin) begin
            w_sym_done_next   = 1'b1;
            w_sym_cnt_next    = w_sym_cnt_inc;
            w_frame_done_next = w_frame_end;
          end
        end
      end
      default: ;
    endcase
  end

  // Control registers: bin index, symbol count and completion strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc_idx      <= 6'd0;
      r_sym_cnt     <= '0;
      r_demap_valid <= 4'b0000;
      r_sym_done    <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_sc_idx      <= w_sc_idx_next;
      r_sym_cnt     <= w_sym_cnt_next;
      r_demap_valid <= w_demap_valid_next;
      r_sym_done    <= w_sym_done_next;
      r_frame_done  <= w_frame_done_next;
    end
  end

  // Frame context: latched only when a non-empty frame is started from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mod          <= 2'b00;
      r_num_sym      <= '0;
      r_bits_per_sym <= 9'd0;
    end else if (w_start_frame) begin
      r_mod          <= i_mod_sel;
      r_num_sym      <= i_num_sym;
      r_bits_per_sym <= f_bits(i_mod_sel);
    end
  end

  // Sample register: loads data bins only, otherwise holds the last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_real <= '0;
      r_data_imag <= '0;
    end else if (w_capture) begin
      r_data_real <= i_data_in_real;
      r_data_imag <= i_data_in_imag;
    end
  end

  assign o_demap_valid   = r_demap_valid;
  assign o_data_out_real = r_data_real;
  assign o_data_out_imag = r_data_imag;
  assign o_bits_per_sym  = r_bits_per_sym;
  assign o_busy          = w_in_run;
  assign o_sym_done      = r_sym_done;
  assign o_frame_done    = r_frame_done;
  assign o_sym_cnt       = r_sym_cnt;

endmodule

// File: tb/tb_demapper_ctrl_wifi.sv
// tb_demapper_ctrl_wifi
// Directed bench for the WiFi demapper sequencer: single-symbol BPSK,
// two-symbol 64-QAM with a gap, zero-length frame, start while busy,
// back-to-back frames, abort mid-symbol and reset mid-frame.

module tb_demapper_ctrl_wifi;

  localparam int DATA_W = 12;
  localparam int SYM_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic              i_abort;
  logic [1:0]        i_mod_sel;
  logic [SYM_W-1:0]  i_num_sym;
  logic              i_valid_in;
  logic [DATA_W-1:0] i_data_in_real;
  logic [DATA_W-1:0] i_data_in_imag;
  logic [3:0]        o_demap_valid;
  logic [DATA_W-1:0] o_data_out_real;
  logic [DATA_W-1:0] o_data_out_imag;
  logic [8:0]        o_bits_per_sym;
  logic              o_busy;
  logic              o_sym_done;
  logic              o_frame_done;
  logic [SYM_W-1:0]  o_sym_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Last data sample the demappers should be holding.
  logic [DATA_W-1:0] exp_re = '0;
  logic [DATA_W-1:0] exp_im = '0;

  demapper_ctrl_wifi #(.DATA_W(DATA_W), .NUM_SC(64), .SYM_W(SYM_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_mod_sel       (i_mod_sel),
    .i_num_sym       (i_num_sym),
    .i_valid_in      (i_valid_in),
    .i_data_in_real  (i_data_in_real),
    .i_data_in_imag  (i_data_in_imag),
    .o_demap_valid   (o_demap_valid),
    .o_data_out_real (o_data_out_real),
    .o_data_out_imag (o_data_out_imag),
    .o_bits_per_sym  (o_bits_per_sym),
    .o_busy          (o_busy),
    .o_sym_done      (o_sym_done),
    .o_frame_done    (o_frame_done),
    .o_sym_cnt       (o_sym_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  // Bin classification straight from the 802.11a subcarrier map.
  function automatic bit is_data(input int b);
    return !(b == 0 || b == 7 || b == 21 || b == 43 || b == 57 ||
             (b >= 27 && b <= 37));
  endfunction

  // One clock with the given sample; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic v, input int re, input int im);
    i_valid_in     = v;
    i_data_in_real = DATA_W'(re);
    i_data_in_imag = DATA_W'(im);
    @(posedge clk);
    #1;
    i_valid_in = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] mod, input int nsym);
    i_mod_sel = mod;
    i_num_sym = SYM_W'(nsym);
    i_start   = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_assert++;
    if ({o_demap_valid, o_data_out_real, o_data_out_imag, o_bits_per_sym, o_busy,
         o_sym_done, o_frame_done, o_sym_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dv=%b re=%h im=%h bits=%0d busy=%b sd=%b fd=%b cnt=%0d, required all 0",
               o_demap_valid, o_data_out_real, o_data_out_imag, o_bits_per_sym,
               o_busy, o_sym_done, o_frame_done, o_sym_cnt);
    end
    // A start while reset is held must have no effect.
    start_frame(2'b11, 3);
    n_assert++;
    if ({o_busy, o_bits_per_sym, o_frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy=%b bits=%0d fd=%b, required 0",
               o_busy, o_bits_per_sym, o_frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5, 5);
    n_assert++;
    if ({o_demap_valid, o_busy, o_sym_done, o_frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_valid: dv=%b busy=%b sd=%b fd=%b, required 0",
               o_demap_valid, o_busy, o_sym_done, o_frame_done);
    end
  endtask

  task automatic test_bpsk_single;
    logic [6:0] exp_ctl;
    logic [3:0] dv;
    int         pulses = 0;
    start_frame(2'b00, 1);
    n_assert++;
    if ({o_busy, o_bits_per_sym, o_sym_cnt, o_demap_valid} !== {1'b1, 9'd48, 12'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL bpsk_start: busy=%b bits=%0d cnt=%0d dv=%b, required 1/48/0/0000",
               o_busy, o_bits_per_sym, o_sym_cnt, o_demap_valid);
    end
    for (int b = 0; b < 64; b++) begin
      drive(1'b1, b, 100 + b);
      dv = is_data(b) ? 4'b0001 : 4'b0000;
      if (is_data(b)) begin
        exp_re = DATA_W'(b);
        exp_im = DATA_W'(100 + b);
      end
      exp_ctl = {dv, b == 63, b == 63, b != 63};
      if (o_demap_valid == 4'b0001) pulses++;
      n_assert++;
      if ({o_demap_valid, o_sym_done, o_frame_done, o_busy} !== exp_ctl) begin
        n_fail++;
        $display("FAIL bpsk_ctl bin %0d: got {dv,sd,fd,busy}=%b required %b", b,
                 {o_demap_valid, o_sym_done, o_frame_done, o_busy}, exp_ctl);
      end
      n_assert++;
      if ({o_data_out_real, o_data_out_imag} !== {exp_re, exp_im}) begin
        n_fail++;
        $display("FAIL bpsk_data bin %0d: got re=%0d im=%0d required re=%0d im=%0d",
                 b, o_data_out_real, o_data_out_imag, exp_re, exp_im);
      end
    end
    n_assert++;
    if (pulses != 48) begin
      n_fail++;
      $display("FAIL bpsk_pulse_count: got %0d required 48", pulses);
    end
    drive(1'b0, 0, 0);
    n_assert++;
    if ({o_busy, o_sym_done, o_frame_done, o_sym_cnt} !== {3'b000, 12'd1}) begin
      n_fail++;
      $display("FAIL bpsk_after: busy=%b sd=%b fd=%b cnt=%0d, required 0/0/0/1",
               o_busy, o_sym_done, o_frame_done, o_sym_cnt);
    end
  endtask

  task automatic test_qam64_gap;
    logic [6:0] exp_ctl;
    logic [3:0] dv;
    int         pulses = 0;
    int         frames = 0;
    start_frame(2'b11, 2);
    n_assert++;
    if ({o_busy, o_bits_per_sym} !== {1'b1, 9'd288}) begin
      n_fail++;
      $display("FAIL qam64_start: busy=%b bits=%0d, required 1/288", o_busy, o_bits_per_sym);
    end
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 64; b++) begin
        if (s == 0 && b == 31) begin
          for (int g = 0; g < 5; g++) begin
            drive(1'b0, 999, 999);
            n_assert++;
            if ({o_demap_valid, o_sym_done, o_frame_done, o_busy} !== 7'b0000_001 ||
                o_data_out_real !== exp_re) begin
              n_fail++;
              $display("FAIL qam64_gap cycle %0d: {dv,sd,fd,busy}=%b re=%0d required 0000001 re=%0d",
                       g, {o_demap_valid, o_sym_done, o_frame_done, o_busy},
                       o_data_out_real, exp_re);
            end
          end
        end
        drive(1'b1, s * 64 + b, -b);
        dv = is_data(b) ? 4'b1000 : 4'b0000;
        if (is_data(b)) begin
          exp_re = DATA_W'(s * 64 + b);
          exp_im = DATA_W'(-b);
        end
        exp_ctl = {dv, b == 63, s == 1 && b == 63, !(s == 1 && b == 63)};
        if (o_demap_valid == 4'b1000) pulses++;
        if (o_frame_done) frames++;
        n_assert++;
        if ({o_demap_valid, o_sym_done, o_frame_done, o_busy} !== exp_ctl) begin
          n_fail++;
          $display("FAIL qam64_ctl sym %0d bin %0d: got %b required %b", s, b,
                   {o_demap_valid, o_sym_done, o_frame_done, o_busy}, exp_ctl);
        end
        n_assert++;
        if ({o_data_out_real, o_data_out_imag} !== {exp_re, exp_im}) begin
          n_fail++;
          $display("FAIL qam64_data sym %0d bin %0d: got re=%h im=%h required re=%h im=%h",
                   s, b, o_data_out_real, o_data_out_imag, exp_re, exp_im);
        end
        if (b == 63) begin
          n_assert++;
          if (o_sym_cnt !== SYM_W'(s + 1)) begin
            n_fail++;
            $display("FAIL qam64_sym_cnt sym %0d: got %0d required %0d", s, o_sym_cnt, s + 1);
          end
        end
      end
    end
    n_assert++;
    if (pulses != 96 || frames != 1) begin
      n_fail++;
      $display("FAIL qam64_counts: pulses=%0d frames=%0d, required 96/1", pulses, frames);
    end
  endtask

  task automatic test_zero_len;
    start_frame(2'b10, 0);
    n_assert++;
    if ({o_frame_done, o_busy, o_demap_valid, o_sym_cnt} !== {2'b10, 4'b0000, 12'd0}) begin
      n_fail++;
      $display("FAIL zero_len_done: fd=%b busy=%b dv=%b cnt=%0d, required 1/0/0000/0",
               o_frame_done, o_busy, o_demap_valid, o_sym_cnt);
    end
    n_assert++;
    if (o_bits_per_sym !== 9'd288) begin
      n_fail++;
      $display("FAIL zero_len_bits: got %0d required 288", o_bits_per_sym);
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, c + 1, c + 1);
      n_assert++;
      if ({o_frame_done, o_busy, o_demap_valid, o_sym_done} !== '0) begin
        n_fail++;
        $display("FAIL zero_len_idle cycle %0d: fd=%b busy=%b dv=%b sd=%b, required 0",
                 c, o_frame_done, o_busy, o_demap_valid, o_sym_done);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [6:0] exp_ctl;
    start_frame(2'b01, 1);
    for (int b = 0; b < 64; b++) begin
      if (b == 20) begin
        i_start   = 1'b1;
        i_mod_sel = 2'b10;
        i_num_sym = SYM_W'(5);
      end
      drive(1'b1, b, b);
      i_start = 1'b0;
      if (is_data(b)) begin
        exp_re = DATA_W'(b);
        exp_im = DATA_W'(b);
      end
      exp_ctl = {is_data(b) ? 4'b0010 : 4'b0000, b == 63, b == 63, b != 63};
      n_assert++;
      if ({o_demap_valid, o_sym_done, o_frame_done, o_busy} !== exp_ctl ||
          o_bits_per_sym !== 9'd96) begin
        n_fail++;
        $display("FAIL busy_start bin %0d: {dv,sd,fd,busy}=%b bits=%0d required %b bits=96",
                 b, {o_demap_valid, o_sym_done, o_frame_done, o_busy}, o_bits_per_sym, exp_ctl);
      end
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int frames = 0;
    start_frame(2'b00, 1);
    for (int b = 0; b < 64; b++) begin
      drive(1'b1, b, 0);
      if (is_data(b)) begin
        exp_re = DATA_W'(b);
        exp_im = '0;
      end
    end
    n_assert++;
    if ({o_frame_done, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_first_done: fd=%b busy=%b required 1/0", o_frame_done, o_busy);
    end
    // Start in the cycle right after the final symbol completes.
    start_frame(2'b01, 1);
    n_assert++;
    if ({o_busy, o_bits_per_sym, o_sym_cnt} !== {1'b1, 9'd96, 12'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b bits=%0d cnt=%0d required 1/96/0",
               o_busy, o_bits_per_sym, o_sym_cnt);
    end
    for (int b = 0; b < 64; b++) begin
      drive(1'b1, 200 + b, b);
      if (is_data(b)) begin
        exp_re = DATA_W'(200 + b);
        exp_im = DATA_W'(b);
      end
      if (o_demap_valid == 4'b0010) pulses++;
      if (o_frame_done) frames++;
      n_assert++;
      if (o_demap_valid !== (is_data(b) ? 4'b0010 : 4'b0000) || o_data_out_real !== exp_re) begin
        n_fail++;
        $display("FAIL b2b_data bin %0d: dv=%b re=%0d required dv=%b re=%0d", b,
                 o_demap_valid, o_data_out_real, is_data(b) ? 4'b0010 : 4'b0000, exp_re);
      end
    end
    n_assert++;
    if (pulses != 48 || frames != 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_counts: pulses=%0d frames=%0d busy=%b required 48/1/0",
               pulses, frames, o_busy);
    end
  endtask

  task automatic test_abort;
    int pulses = 0;
    int first  = -1;
    start_frame(2'b10, 2);
    for (int b = 0; b < 64; b++) begin
      drive(1'b1, b, 50);
      if (is_data(b)) begin
        exp_re = DATA_W'(b);
        exp_im = DATA_W'(50);
      end
    end
    n_assert++;
    if ({o_sym_done, o_frame_done, o_busy, o_sym_cnt} !== {3'b101, 12'd1}) begin
      n_fail++;
      $display("FAIL abort_sym0: sd=%b fd=%b busy=%b cnt=%0d required 1/0/1/1",
               o_sym_done, o_frame_done, o_busy, o_sym_cnt);
    end
    for (int b = 0; b < 40; b++) begin
      drive(1'b1, 300 + b, 60);
      if (is_data(b)) begin
        exp_re = DATA_W'(300 + b);
        exp_im = DATA_W'(60);
      end
    end
    // Abort together with bin 40: the sample is discarded.
    i_abort = 1'b1;
    drive(1'b1, 340, 61);
    i_abort = 1'b0;
    n_assert++;
    if ({o_demap_valid, o_sym_done, o_frame_done, o_busy} !== '0 || o_sym_cnt !== 12'd1) begin
      n_fail++;
      $display("FAIL abort_edge: {dv,sd,fd,busy}=%b cnt=%0d required 0000000 cnt=1",
               {o_demap_valid, o_sym_done, o_frame_done, o_busy}, o_sym_cnt);
    end
    n_assert++;
    if ({o_data_out_real, o_data_out_imag} !== {exp_re, exp_im}) begin
      n_fail++;
      $display("FAIL abort_data_hold: re=%0d im=%0d required re=%0d im=%0d",
               o_data_out_real, o_data_out_imag, exp_re, exp_im);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 41 + c, 0);
      n_assert++;
      if ({o_demap_valid, o_sym_done, o_frame_done, o_busy} !== '0) begin
        n_fail++;
        $display("FAIL abort_idle cycle %0d: {dv,sd,fd,busy}=%b required 0", c,
                 {o_demap_valid, o_sym_done, o_frame_done, o_busy});
      end
    end
    start_frame(2'b10, 1);
    for (int b = 0; b < 64; b++) begin
      drive(1'b1, b, 7);
      if (o_demap_valid == 4'b0100) begin
        pulses++;
        if (first < 0) first = int'(o_data_out_real);
      end
      if (b == 63) begin
        n_assert++;
        if ({o_sym_done, o_frame_done, o_busy} !== 3'b110) begin
          n_fail++;
          $display("FAIL abort_restart_end: sd=%b fd=%b busy=%b required 1/1/0",
                   o_sym_done, o_frame_done, o_busy);
        end
      end
    end
    n_assert++;
    if (pulses != 48 || first != 1) begin
      n_fail++;
      $display("FAIL abort_restart: pulses=%0d first=%0d required 48/1", pulses, first);
    end
  endtask

  task automatic test_reset_mid_frame;
    start_frame(2'b01, 3);
    for (int b = 0; b < 10; b++) drive(1'b1, b + 1, b + 1);
    i_valid_in     = 1'b1;
    i_data_in_real = DATA_W'(11);
    #2;
    rst = 1'b1;
    #1;
    exp_re = '0;
    exp_im = '0;
    n_assert++;
    if ({o_demap_valid, o_data_out_real, o_data_out_imag, o_bits_per_sym, o_busy,
         o_sym_done, o_frame_done, o_sym_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: dv=%b re=%0d im=%0d bits=%0d busy=%b cnt=%0d, required all 0",
               o_demap_valid, o_data_out_real, o_data_out_imag, o_bits_per_sym, o_busy, o_sym_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 64; c++) begin
      drive(1'b1, c, c);
      n_assert++;
      if ({o_demap_valid, o_busy, o_sym_done, o_frame_done, o_data_out_real} !== '0) begin
        n_fail++;
        $display("FAIL reset_no_start cycle %0d: dv=%b busy=%b sd=%b fd=%b re=%0d required 0",
                 c, o_demap_valid, o_busy, o_sym_done, o_frame_done, o_data_out_real);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_mod_sel      = 2'b00;
    i_num_sym      = '0;
    i_valid_in     = 1'b0;
    i_data_in_real = '0;
    i_data_in_imag = '0;
    test_reset;
    test_bpsk_single;
    test_qam64_gap;
    test_zero_len;
    test_start_while_busy;
    test_back_to_back;
    test_abort;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demapper_ctrl_wifi.md
Name: demapper_ctrl_wifi

Overview:
Frame-level sequencer that sits between the WiFi receiver FFT output and the bank of constellation demappers (BPSK/QPSK/16-QAM/64-QAM).
- Latches the frame's modulation and OFDM symbol count.
- Tracks the subcarrier index of the incoming 64-bin stream and discards DC, null and pilot bins.
- Steers the 48 data subcarriers per symbol to exactly one demapper through a one-hot valid.
- Reports symbol and frame completion to the downstream deinterleaver/decoder control.

Parameters:
DATA_W, 12, width of each I/Q sample
NUM_SC, 64, FFT bins per OFDM symbol; fixed at 64, present for documentation only
SYM_W, 12, width of the symbol counter and of num_sym

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; latches mod_sel and num_sym; honoured only in IDLE
abort  in  1  terminates the frame in progress; honoured only in RUN
mod_sel  in  2  00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM
num_sym  in  SYM_W  data OFDM symbols in the frame
valid_in  in  1  sample valid from FFT, bins in natural order 0..63
data_in_real  in  DATA_W  FFT bin, I component, two's complement
data_in_imag  in  DATA_W  FFT bin, Q component, two's complement
demap_valid  out  4  one-hot: bit0 BPSK, bit1 QPSK, bit2 16-QAM, bit3 64-QAM
data_out_real  out  DATA_W  registered I component to demappers
data_out_imag  out  DATA_W  registered Q component to demappers
bits_per_sym  out  9  coded bits per symbol for latched mode: 48/96/192/288
busy  out  1  high while in RUN
sym_done  out  1  one-cycle pulse coincident with a symbol's last data output cycle
frame_done  out  1  one-cycle pulse coincident with the final sym_done
sym_cnt  out  SYM_W  symbols completed in the current frame

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; state IDLE; internal sc_idx = 0; latched mode = 00.
- FSM states: IDLE, RUN.
- IDLE:
  - valid_in ignored; demap_valid = 0.
  - start && num_sym != 0: latch mod_sel and num_sym, load bits_per_sym, clear sym_cnt and sc_idx, go to RUN; busy = 1 next cycle.
  - start && num_sym == 0: frame_done pulses on the next cycle; sym_cnt = 0; stay IDLE.
- RUN, per cycle with valid_in = 1:
  - sc_idx increments, wrapping 63 -> 0.
  - Non-data bins are dropped, with demap_valid = 0 next cycle: 0 (DC), 7, 21, 43, 57 (pilots), 27..37 (nulls).
  - Remaining 48 bins are data. At the next edge: data_out_real/imag <= input, and demap_valid <= one-hot of latched mode.
  - Latency: exactly 1 clock.
- data_out_* holds its last value when demap_valid = 0.
- valid_in = 0: no state change; sc_idx holds; gaps are allowed anywhere, including mid-symbol.
- Bin 63 accepted (always a data bin) at cycle T. At the end of T:
  - sym_done <= 1, sym_cnt <= sym_cnt + 1.
  - If sym_cnt + 1 == latched num_sym: frame_done <= 1, busy <= 0, state <= IDLE.
  - A start in cycle T+1 is accepted.
- start during RUN: ignored; latched values are unchanged.
- abort during RUN, at the same edge:
  - state <= IDLE, busy <= 0, demap_valid <= 0, sc_idx <= 0.
  - No sym_done and no frame_done.
  - A valid_in in the abort cycle is discarded.
  - sym_cnt holds its count.
- abort in the same cycle as bin 63: abort wins; no pulses are generated.
- Reset asserted mid-frame: immediate return to reset values; partial symbols are lost.
- bits_per_sym: 48 × N_BPSC, with N_BPSC = 1/2/4/6. It is constant from the start edge until the next accepted start.

Test Plan:
1. Single BPSK symbol: reset, start, mod_sel = 00, num_sym = 1; 64 back-to-back bins with real = bin index -> 48 demap_valid = 0001 pulses; data_out_real sequence 1..6, 8..20, 22..26, 38..42, 44..56, 58..63; sym_done and frame_done high together with the bin-63 output; busy low the following cycle.
2. 64-QAM, 2 symbols with a valid_in gap: mod_sel = 11, num_sym = 2; valid_in low 5 cycles after bin 30 of symbol 0 -> bits_per_sym = 288; 96 demap_valid = 1000 pulses; sym_cnt 1 then 2; one frame_done, on the second sym_done only.
3. Zero-length frame: start with num_sym = 0 -> frame_done one cycle later; busy never asserts; demap_valid stays 0.
4. Start while busy: QPSK frame, start pulsed with mod_sel = 10 during bin 20 -> demap_valid stays 0010; bits_per_sym stays 96.
5. Abort mid-symbol: 16-QAM, abort at bin 40 -> no sym_done or frame_done; busy low next cycle. A new start with num_sym = 1 then yields 48 outputs from bin 1 onward.
6. Reset mid-frame: assert reset at bin 10 of symbol 0 -> all outputs 0 asynchronously; after release, valid_in without start produces no demap_valid.
